// File: rtl/down_counter_load.sv
// Loadable countdown counter: accepts a start value over valid/ready, counts down on enable, pulses done at zero.
// Latency: count = load_value after the load edge; done high the cycle after the edge that brings count to 0.
// Backpressure: load_ready is high only in IDLE; offers made in RUN or DONE are ignored, not queued.
module down_counter_load #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // State and count registers; synchronous reset aborts any countdown without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next-state and next-count decode; count == 1 is the last decrement so it never wraps below zero.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    count_nxt = load_value;
                    state_nxt = (load_value == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (enable) begin
                    if (count > ONE) begin
                        count_nxt = count - ONE;
                    end else begin
                        count_nxt = '0;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, never on inputs.
    always_comb begin
        load_ready = (state == IDLE);
        busy       = (state == RUN);
        done       = (state == DONE);
    end

endmodule

// File: tb/tb_down_counter_load.sv
// Directed bench for down_counter_load with hand-computed expected values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// All waits are fixed cycle counts or bounded loops, so the run always ends.
module tb_down_counter_load;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [2:0] load_value;
    logic       enable;
    logic [2:0] count;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    down_counter_load #(.WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .enable     (enable),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int exp_t3 [5] = '{5, 5, 5, 4, 3};
    bit en_t3  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int done_cnt;
        int last_done;
        bit seen;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_value = 3'd0;
        enable     = 1'b0;

        // T1: reset state
        step();
        step();
        chk("t1_count", count, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_ready", load_ready, 1);
        reset = 1'b0;
        step();
        chk("t1_idle_ready", load_ready, 1);

        // T2: load 5, enable held
        load_valid = 1'b1;
        load_value = 3'd5;
        enable     = 1'b1;
        step();
        load_valid = 1'b0;
        chk("t2_load_count", count, 5);
        chk("t2_busy", busy, 1);
        chk("t2_ready", load_ready, 0);
        for (int v = 4; v >= 1; v--) begin
            step();
            chk("t2_count", count, v);
            chk("t2_nodone", done, 0);
        end
        step();
        chk("t2_zero", count, 0);
        chk("t2_done", done, 1);
        chk("t2_done_busy", busy, 0);
        chk("t2_done_ready", load_ready, 0);
        step();
        chk("t2_done_drop", done, 0);
        chk("t2_idle_ready", load_ready, 1);

        // T3: load 6, enable pattern 1,0,0,1,1
        load_valid = 1'b1;
        load_value = 3'd6;
        enable     = 1'b0;
        step();
        load_valid = 1'b0;
        chk("t3_load_count", count, 6);
        for (int i = 0; i < 5; i++) begin
            enable = en_t3[i];
            step();
            chk("t3_count", count, exp_t3[i]);
            chk("t3_busy", busy, 1);
            chk("t3_nodone", done, 0);
        end
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = done;
        end
        chk("t3_drain_done", seen, 1);
        step();

        // T4: load 0 goes straight to DONE; load offered during RUN is ignored
        load_valid = 1'b1;
        load_value = 3'd0;
        step();
        load_valid = 1'b0;
        chk("t4_zero_done", done, 1);
        chk("t4_zero_busy", busy, 0);
        chk("t4_zero_count", count, 0);
        step();
        chk("t4_idle", load_ready, 1);
        chk("t4_idle_done", done, 0);
        load_valid = 1'b1;
        load_value = 3'd3;
        enable     = 1'b0;
        step();
        chk("t4_run_count", count, 3);
        load_value = 3'd7;
        step();
        step();
        chk("t4_ignore_count", count, 3);
        chk("t4_ignore_ready", load_ready, 0);
        load_valid = 1'b0;
        enable     = 1'b1;
        step();
        step();
        step();
        chk("t4_run_done", done, 1);
        step();

        // T5: reset at count=2 aborts without done
        load_valid = 1'b1;
        load_value = 3'd4;
        enable     = 1'b1;
        step();
        load_valid = 1'b0;
        chk("t5_count4", count, 4);
        step();
        step();
        chk("t5_count2", count, 2);
        reset      = 1'b1;
        load_valid = 1'b1;
        load_value = 3'd6;
        step();
        reset      = 1'b0;
        load_valid = 1'b0;
        chk("t5_rst_count", count, 0);
        chk("t5_rst_ready", load_ready, 1);
        chk("t5_rst_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t5_nodone", done, 0);
            chk("t5_hold", count, 0);
            step();
        end

        // T6: back-to-back loads of 2, each offered on the IDLE cycle after DONE.
        // States per round: RUN(2), RUN(1), DONE, IDLE -> done pulses 4 edges apart.
        done_cnt  = 0;
        last_done = 0;
        enable    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_value = 3'd2;
            step();
            load_valid = 1'b0;
            chk("t6_count2", count, 2);
            step();
            chk("t6_count1", count, 1);
            step();
            chk("t6_done", done, 1);
            chk("t6_zero", count, 0);
            if (done) begin
                if (done_cnt > 0) chk("t6_period", cyc - last_done, 4);
                done_cnt++;
                last_done = cyc;
            end
            step();
            chk("t6_idle", load_ready, 1);
            chk("t6_done_drop", done, 0);
        end
        chk("t6_pulses", done_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
